// File: rtl/ddr3_rd_burst_ctrl.sv
// rtl/ddr3_rd_burst_ctrl.sv - multi-burst DDR3 AXI read master with protocol error counting
// Splits one transfer into AXI bursts, keeps up to MAX_OUTST in flight, forwards data one cycle later.
module ddr3_rd_burst_ctrl #(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int MEM_DQ_WIDTH    = 16,
  parameter int LEN_WIDTH       = 4,
  parameter int XFER_WIDTH      = 16,
  parameter int MAX_OUTST       = 4,
  parameter int BEAT_ADDR_INC   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_req,
  output logic                         rd_ready,
  input  logic [CTRL_ADDR_WIDTH-1:0]   rd_start_addr,
  input  logic [XFER_WIDTH-1:0]        rd_beats,
  input  logic [3:0]                   rd_id,
  input  logic                         rd_ap,
  input  logic                         ds_afull,
  output logic                         rd_valid,
  output logic [MEM_DQ_WIDTH*8-1:0]    rd_data,
  output logic                         rd_last,
  output logic                         rd_done_p,
  output logic                         rd_busy,
  output logic [CTRL_ADDR_WIDTH-1:0]   axi_araddr,
  output logic [3:0]                   axi_aruser_id,
  output logic                         axi_aruser_ap,
  output logic [LEN_WIDTH-1:0]         axi_arlen,
  output logic                         axi_arvalid,
  input  logic                         axi_arready,
  input  logic [MEM_DQ_WIDTH*8-1:0]    axi_rdata,
  input  logic [3:0]                   axi_rid,
  input  logic                         axi_rlast,
  input  logic                         axi_rvalid,
  output logic                         err_flag,
  output logic [7:0]                   err_cnt
);
  localparam int DW        = MEM_DQ_WIDTH * 8;
  localparam int PTR_W     = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OUT_W     = $clog2(MAX_OUTST + 1);
  localparam int MAX_BURST = 2 ** LEN_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;

  logic [CTRL_ADDR_WIDTH-1:0] r_addr;
  logic [XFER_WIDTH-1:0]      r_beats, r_remain, r_rcv_cnt;
  logic [3:0]                 r_id;
  logic                       r_ap;
  logic                       r_arvalid;
  logic [LEN_WIDTH-1:0]       r_arlen;
  logic [LEN_WIDTH-1:0]       r_len_fifo [MAX_OUTST];
  logic [PTR_W-1:0]           r_wr_ptr, r_rd_ptr;
  logic [OUT_W-1:0]           r_outst;
  logic [LEN_WIDTH-1:0]       r_beat_cnt;
  logic                       r_rd_valid, r_rd_last;
  logic [DW-1:0]              r_rd_data;
  logic                       r_err_flag;
  logic [7:0]                 r_err_cnt;

  logic                       w_accept, w_ar_hs, w_can_issue;
  logic [XFER_WIDTH-1:0]      w_burst, w_remain_after;
  logic [LEN_WIDTH:0]         w_ar_beats;
  logic [CTRL_ADDR_WIDTH-1:0] w_addr_inc;
  logic                       w_beat, w_at_end, w_pop;
  logic                       w_err_id, w_err_miss, w_err_early, w_err_stray;
  logic [2:0]                 w_err_sum;
  logic [8:0]                 w_err_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_accept       = (r_state == S_IDLE) && rd_req;
  assign w_ar_hs        = r_arvalid && axi_arready;
  assign w_burst        = (r_remain >= XFER_WIDTH'(MAX_BURST)) ? XFER_WIDTH'(MAX_BURST) : r_remain;
  assign w_ar_beats     = {1'b0, r_arlen} + (LEN_WIDTH+1)'(1);
  assign w_addr_inc     = CTRL_ADDR_WIDTH'(w_ar_beats) * CTRL_ADDR_WIDTH'(BEAT_ADDR_INC);
  assign w_remain_after = r_remain - XFER_WIDTH'(w_ar_beats);
  // ds_afull only gates raising arvalid; once raised the request is held until arready
  assign w_can_issue    = (r_state == S_ISSUE) && !r_arvalid && (r_outst < OUT_W'(MAX_OUTST))
                          && !ds_afull && (r_remain != '0);

  assign w_beat      = axi_rvalid && (r_outst != '0);
  assign w_at_end    = (r_beat_cnt == r_len_fifo[r_rd_ptr]);
  assign w_pop       = w_beat && (axi_rlast || w_at_end);
  assign w_err_id    = w_beat && (axi_rid != r_id);
  assign w_err_miss  = w_beat && w_at_end && !axi_rlast;
  assign w_err_early = w_beat && axi_rlast && !w_at_end;
  assign w_err_stray = axi_rvalid && (r_outst == '0);
  assign w_err_sum   = 3'(w_err_id) + 3'(w_err_miss) + 3'(w_err_early) + 3'(w_err_stray);
  assign w_err_next  = {1'b0, r_err_cnt} + 9'(w_err_sum);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    rd_ready  = 1'b0;
    rd_done_p = 1'b0;
    case (r_state)
      S_IDLE: begin
        rd_ready = 1'b1;
        if (rd_req) w_next = (rd_beats == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: if (w_ar_hs && (w_remain_after == '0)) w_next = S_DRAIN;
      S_DRAIN: if ((r_outst == '0) && (r_rcv_cnt == r_beats)) w_next = S_DONE;
      S_DONE: begin
        rd_done_p = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_beats    <= '0;
      r_remain   <= '0;
      r_rcv_cnt  <= '0;
      r_id       <= '0;
      r_ap       <= 1'b0;
      r_arvalid  <= 1'b0;
      r_arlen    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_outst    <= '0;
      r_beat_cnt <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
      r_err_flag <= 1'b0;
      r_err_cnt  <= '0;
      for (int i = 0; i < MAX_OUTST; i++) r_len_fifo[i] <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= rd_start_addr;
        r_beats  <= rd_beats;
        r_remain <= rd_beats;
        r_id     <= rd_id;
        r_ap     <= rd_ap;
      end else if (w_ar_hs) begin
        r_addr   <= r_addr + w_addr_inc;
        r_remain <= w_remain_after;
      end

      if (w_ar_hs) begin
        r_arvalid              <= 1'b0;
        r_len_fifo[r_wr_ptr]   <= r_arlen;
        r_wr_ptr               <= ptr_inc(r_wr_ptr);
      end else if (w_can_issue) begin
        r_arvalid <= 1'b1;
        r_arlen   <= LEN_WIDTH'(w_burst - XFER_WIDTH'(1));
      end

      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_ar_hs, w_pop})
        2'b10:   r_outst <= r_outst + OUT_W'(1);
        2'b01:   r_outst <= r_outst - OUT_W'(1);
        default: r_outst <= r_outst;
      endcase

      // A missing rlast still closes the burst so the next one lines up with its length
      r_rd_valid <= w_beat;
      r_rd_last  <= w_beat && (r_rcv_cnt == r_beats - XFER_WIDTH'(1));
      if (w_beat) begin
        r_rd_data  <= axi_rdata;
        r_beat_cnt <= w_pop ? '0 : r_beat_cnt + LEN_WIDTH'(1);
      end
      if (w_accept)    r_rcv_cnt <= '0;
      else if (w_beat) r_rcv_cnt <= r_rcv_cnt + XFER_WIDTH'(1);

      if (w_accept) begin
        r_err_flag <= 1'b0;
        r_err_cnt  <= '0;
      end else if (w_err_sum != '0) begin
        r_err_flag <= 1'b1;
        r_err_cnt  <= w_err_next[8] ? 8'hFF : w_err_next[7:0];
      end
    end
  end

  assign rd_busy       = ~rd_ready;
  assign rd_valid      = r_rd_valid;
  assign rd_data       = r_rd_data;
  assign rd_last       = r_rd_last;
  assign axi_araddr    = r_addr;
  assign axi_aruser_id = r_id;
  assign axi_aruser_ap = r_ap;
  assign axi_arlen     = r_arlen;
  assign axi_arvalid   = r_arvalid;
  assign err_flag      = r_err_flag;
  assign err_cnt       = r_err_cnt;
endmodule

// File: tb/tb_ddr3_rd_burst_ctrl.sv
// tb/tb_ddr3_rd_burst_ctrl.sv - directed bench for ddr3_rd_burst_ctrl
// Table of transfers plus hand sequences for stalls, afull, zero length, errors and reset.
module tb_ddr3_rd_burst_ctrl;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int LW = 4;
  localparam int XW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_start_addr = '0;
  logic [XW-1:0] rd_beats = '0;
  logic [3:0]    rd_id = '0;
  logic          rd_ap = 1'b0;
  logic          ds_afull = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last, rd_done_p, rd_busy;
  logic [AW-1:0] axi_araddr;
  logic [3:0]    axi_aruser_id;
  logic          axi_aruser_ap;
  logic [LW-1:0] axi_arlen;
  logic          axi_arvalid;
  logic          axi_arready = 1'b1;
  logic [DW-1:0] axi_rdata = '0;
  logic [3:0]    axi_rid = '0;
  logic          axi_rlast = 1'b0;
  logic          axi_rvalid = 1'b0;
  logic          err_flag;
  logic [7:0]    err_cnt;

  always #5 clk = ~clk;

  ddr3_rd_burst_ctrl dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_ready(rd_ready),
    .rd_start_addr(rd_start_addr), .rd_beats(rd_beats), .rd_id(rd_id), .rd_ap(rd_ap),
    .ds_afull(ds_afull), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .rd_done_p(rd_done_p), .rd_busy(rd_busy), .axi_araddr(axi_araddr),
    .axi_aruser_id(axi_aruser_id), .axi_aruser_ap(axi_aruser_ap), .axi_arlen(axi_arlen),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_rdata(axi_rdata),
    .axi_rid(axi_rid), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .err_flag(err_flag), .err_cnt(err_cnt)
  );

  // controls written only by the main sequence
  int       gen = 0, stray_gen = 0, stall_until = 0;
  int       bad_rid_beat = -1, drop_rlast_burst = -1;
  logic     r_enable = 1'b1;
  logic [3:0] cur_id = '0;

  // state written only by the bus model
  int       cyc = 0, seen_gen = 0, seen_stray = 0;
  int       n_valid, n_last, last_pos, n_done, n_ar, data_err, stab_err, id_err;
  int       sent, beat_in, burst_idx;
  logic [AW-1:0] ar_addr[$];
  int       ar_len[$], ar_snap[$], q_len[$];
  logic     prev_pending = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [LW-1:0] prev_len = '0;

  function automatic logic [DW-1:0] pat(input int i);
    return {32'hA5C3_0F1E, 64'h0123_4567_89AB_CDEF, 32'(i)};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (gen != seen_gen) begin
      seen_gen = gen;
      n_valid = 0; n_last = 0; last_pos = 0; n_done = 0; n_ar = 0;
      data_err = 0; stab_err = 0; id_err = 0; sent = 0; beat_in = 0; burst_idx = 0;
      ar_addr.delete(); ar_len.delete(); ar_snap.delete(); q_len.delete();
    end
    if (rd_valid) begin
      if (rd_data !== pat(n_valid)) data_err++;
      if (rd_last) begin n_last++; last_pos = n_valid + 1; end
      n_valid++;
    end
    if (rd_done_p) n_done++;
    if (prev_pending && (!axi_arvalid || axi_araddr != prev_addr || axi_arlen != prev_len)) stab_err++;

    if (stray_gen != seen_stray) begin
      seen_stray = stray_gen;
      axi_rvalid = 1'b1; axi_rlast = 1'b1; axi_rid = cur_id; axi_rdata = pat(999);
    end else if (r_enable && q_len.size() > 0) begin
      axi_rvalid = 1'b1;
      axi_rdata  = pat(sent);
      axi_rid    = (sent == bad_rid_beat) ? (cur_id ^ 4'hF) : cur_id;
      axi_rlast  = (beat_in == q_len[0]) && (burst_idx != drop_rlast_burst);
      if (beat_in == q_len[0]) begin
        void'(q_len.pop_front());
        beat_in = 0;
        burst_idx++;
      end else beat_in++;
      sent++;
    end else begin
      axi_rvalid = 1'b0; axi_rlast = 1'b0;
    end

    axi_arready  = (cyc >= stall_until);
    prev_pending = axi_arvalid && !axi_arready;
    prev_addr    = axi_araddr;
    prev_len     = axi_arlen;
    if (axi_arvalid && axi_arready) begin
      ar_addr.push_back(axi_araddr);
      ar_len.push_back(int'(axi_arlen));
      ar_snap.push_back(burst_idx);
      q_len.push_back(int'(axi_arlen));
      if (axi_aruser_id != cur_id) id_err++;
      n_ar++;
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] qaddr(input int idx);
    return (idx >= 0 && idx < ar_addr.size()) ? 64'(ar_addr[idx]) : 64'hDEAD_BEEF;
  endfunction

  function automatic logic [63:0] qlen(input int idx);
    return (idx >= 0 && idx < ar_len.size()) ? 64'(ar_len[idx]) : 64'hDEAD_BEEF;
  endfunction

  task automatic start_xfer(input logic [AW-1:0] a, input int beats, input logic [3:0] id);
    gen++;
    cur_id = id;
    rd_start_addr = a;
    rd_beats = XW'(beats);
    rd_id = id;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000 && n_done == 0; i++) tick();
    chk({name, "_done_seen"}, 64'(n_done), 64'd1);
    tick();
    tick();
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    int            beats;
    logic [3:0]    id;
    int            n_ar;
    logic [AW-1:0] addr0;
    int            len0;
    logic [AW-1:0] addr_l;
    int            len_l;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{addr:28'h100,     beats:40,  id:4'd3, n_ar:3, addr0:28'h100,     len0:15, addr_l:28'h200,  len_l:7};
    vecs[1] = '{addr:28'h0,       beats:1,   id:4'd1, n_ar:1, addr0:28'h0,       len0:0,  addr_l:28'h0,    len_l:0};
    vecs[2] = '{addr:28'h40,      beats:16,  id:4'd9, n_ar:1, addr0:28'h40,      len0:15, addr_l:28'h40,   len_l:15};
    vecs[3] = '{addr:28'h1000,    beats:17,  id:4'd2, n_ar:2, addr0:28'h1000,    len0:15, addr_l:28'h1080, len_l:0};
    vecs[4] = '{addr:28'hFFFFF80, beats:32,  id:4'hE, n_ar:2, addr0:28'hFFFFF80, len0:15, addr_l:28'h0,    len_l:15};
    vecs[5] = '{addr:28'h2000,    beats:100, id:4'd6, n_ar:7, addr0:28'h2000,    len0:15, addr_l:28'h2300, len_l:3};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_rd_ready", 64'(rd_ready), 64'd1);
    chk("reset_rd_busy", 64'(rd_busy), 64'd0);
    chk("reset_arvalid", 64'(axi_arvalid), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_err_cnt", 64'(err_cnt), 64'd0);
    chk("reset_done", 64'(rd_done_p), 64'd0);

    for (int v = 0; v < 6; v++) begin
      rd_ap = v[0];
      start_xfer(vecs[v].addr, vecs[v].beats, vecs[v].id);
      wait_done($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_n_ar", v), 64'(n_ar), 64'(vecs[v].n_ar));
      chk($sformatf("vec%0d_addr0", v), qaddr(0), 64'(vecs[v].addr0));
      chk($sformatf("vec%0d_len0", v), qlen(0), 64'(vecs[v].len0));
      chk($sformatf("vec%0d_addr_last", v), qaddr(vecs[v].n_ar - 1), 64'(vecs[v].addr_l));
      chk($sformatf("vec%0d_len_last", v), qlen(vecs[v].n_ar - 1), 64'(vecs[v].len_l));
      chk($sformatf("vec%0d_n_valid", v), 64'(n_valid), 64'(vecs[v].beats));
      chk($sformatf("vec%0d_n_last", v), 64'(n_last), 64'd1);
      chk($sformatf("vec%0d_last_pos", v), 64'(last_pos), 64'(vecs[v].beats));
      chk($sformatf("vec%0d_n_done", v), 64'(n_done), 64'd1);
      chk($sformatf("vec%0d_data_err", v), 64'(data_err), 64'd0);
      chk($sformatf("vec%0d_arid_err", v), 64'(id_err), 64'd0);
      chk($sformatf("vec%0d_ap", v), 64'(axi_aruser_ap), 64'(v[0]));
      chk($sformatf("vec%0d_err_cnt", v), 64'(err_cnt), 64'd0);
      chk($sformatf("vec%0d_ready", v), 64'(rd_ready), 64'd1);
    end
    rd_ap = 1'b0;

    // arready withheld: request must be held unchanged
    stall_until = cyc + 12;
    start_xfer(28'h300, 20, 4'd4);
    repeat (5) tick();
    chk("stall_arvalid", 64'(axi_arvalid), 64'd1);
    chk("stall_no_ar", 64'(n_ar), 64'd0);
    chk("stall_araddr", 64'(axi_araddr), 64'h300);
    chk("stall_arlen", 64'(axi_arlen), 64'd15);
    wait_done("stall");
    chk("stall_n_ar", 64'(n_ar), 64'd2);
    chk("stall_stable", 64'(stab_err), 64'd0);
    chk("stall_addr_last", qaddr(1), 64'h380);
    chk("stall_len_last", qlen(1), 64'd3);

    // downstream almost full at accept
    ds_afull = 1'b1;
    start_xfer(28'h500, 16, 4'd8);
    repeat (8) tick();
    chk("afull_no_arvalid", 64'(axi_arvalid), 64'd0);
    chk("afull_no_ar", 64'(n_ar), 64'd0);
    ds_afull = 1'b0;
    wait_done("afull");
    chk("afull_n_ar", 64'(n_ar), 64'd1);
    chk("afull_n_valid", 64'(n_valid), 64'd16);

    // zero-length transfer
    start_xfer(28'h700, 0, 4'd2);
    chk("zero_done_pulse", 64'(rd_done_p), 64'd1);
    tick();
    chk("zero_done_clear", 64'(rd_done_p), 64'd0);
    chk("zero_ready", 64'(rd_ready), 64'd1);
    repeat (3) tick();
    chk("zero_no_ar", 64'(n_ar), 64'd0);
    chk("zero_n_done", 64'(n_done), 64'd1);

    // data withheld: outstanding limit
    r_enable = 1'b0;
    start_xfer(28'h0, 128, 4'd1);
    repeat (30) tick();
    chk("outst_n_ar4", 64'(n_ar), 64'd4);
    chk("outst_busy", 64'(rd_busy), 64'd1);
    r_enable = 1'b1;
    wait_done("outst");
    chk("outst_n_ar8", 64'(n_ar), 64'd8);
    chk("outst_ar5_after_rlast", 64'((ar_snap.size() > 4) ? ar_snap[4] >= 1 : 1'b0), 64'd1);
    chk("outst_n_valid", 64'(n_valid), 64'd128);
    chk("outst_last_pos", 64'(last_pos), 64'd128);

    // protocol errors: bad rid on beat 3, missing rlast on second burst
    bad_rid_beat = 3;
    drop_rlast_burst = 1;
    start_xfer(28'h100, 40, 4'd5);
    wait_done("err");
    bad_rid_beat = -1;
    drop_rlast_burst = -1;
    chk("err_cnt", 64'(err_cnt), 64'd2);
    chk("err_flag", 64'(err_flag), 64'd1);
    chk("err_n_valid", 64'(n_valid), 64'd40);
    chk("err_last_pos", 64'(last_pos), 64'd40);
    chk("err_addr1", qaddr(1), 64'h180);

    // reset while draining, then a stray beat
    r_enable = 1'b0;
    start_xfer(28'h40, 16, 4'd7);
    repeat (10) tick();
    chk("drain_n_ar", 64'(n_ar), 64'd1);
    chk("drain_busy", 64'(rd_busy), 64'd1);
    rst = 1'b1;
    tick();
    chk("rst_rd_ready", 64'(rd_ready), 64'd1);
    chk("rst_rd_busy", 64'(rd_busy), 64'd0);
    chk("rst_arvalid", 64'(axi_arvalid), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_done", 64'(rd_done_p), 64'd0);
    rst = 1'b0;
    gen++;
    stray_gen++;
    tick();
    tick();
    chk("stray_err_cnt", 64'(err_cnt), 64'd1);
    chk("stray_err_flag", 64'(err_flag), 64'd1);
    tick();
    chk("stray_not_forwarded", 64'(n_valid), 64'd0);
    chk("stray_ready", 64'(rd_ready), 64'd1);
    r_enable = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
